dma_in_mem_bridge: RTL and testbench
====================================

Name: dma_in_mem_bridge

Overview:
- Sits directly downstream of the dma_in peripheral's i0 memory port. Accepts its word-addressed write stream and buffers it in a small FIFO.
- Commits the buffered writes to a single-port, one-cycle-latency data SRAM. The core shares that SRAM through a read port that this block arbitrates against the DMA writes.
- Drops and counts out-of-window writes, and reports drain status so firmware knows when captured samples are resident.

Parameters:
- MEM_AW, 10, SRAM word-address width; the window is 2^MEM_AW words.
- BASE_ADDR, 32'h0000_0000, first i0 word address mapped to SRAM word 0.
- FIFO_DEPTH, 4, write FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8, consecutive cycles a pending write may lose arbitration before it is forced through.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i0_addr  in  32  write word address from dma_in
- i0_data  in  32  write data
- i0_valid  in  1  write request
- i0_ready  out  1  FIFO can accept
- rd_req  in  1  core read request; held until rd_gnt
- rd_addr  in  MEM_AW  core read word address
- rd_gnt  out  1  read accepted this cycle
- rd_data  out  32  read data
- rd_dvalid  out  1  rd_data valid
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  MEM_AW  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en with !mem_we
- drop_clr  in  1  clears drop_cnt and drop_err
- drop_cnt  out  16  out-of-window writes dropped, saturating
- drop_err  out  1  sticky: at least one drop
- wr_cnt  out  32  SRAM writes committed, wraps
- idle  out  1  FIFO empty and no SRAM write in flight

Behaviour:
- Reset (rst_n low, async) puts the block in the following state:
  - FIFO empty.
  - i0_ready=0 while reset is asserted; i0_ready=1 from the first clock after release.
  - rd_gnt=0, rd_dvalid=0, rd_data=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - drop_cnt=0, drop_err=0, wr_cnt=0, idle=1, starve counter 0.
  - Reset mid-burst discards buffered writes; no partial SRAM write is issued after release.
- Input handshake:
  - A transfer occurs when i0_valid && i0_ready.
  - i0_ready = !fifo_full; it is registered-free but depends only on FIFO state, not on i0_valid.
- Window check at FIFO input:
  - off = i0_addr - BASE_ADDR, computed in 32-bit modular arithmetic.
  - In-window when off < 2^MEM_AW. In-window beats are pushed with addr = off[MEM_AW-1:0].
  - Out-of-window beats are still accepted (i0_ready is honoured) but not pushed. They increment drop_cnt, which saturates at 16'hFFFF, and set drop_err.
  - drop_clr takes effect the cycle after assertion. If a drop occurs in the same cycle as drop_clr, the result is drop_cnt=1 and drop_err=1.
- FIFO:
  - Push and pop in the same cycle when full is legal: occupancy is unchanged and i0_ready stays 0 that cycle.
  - Pop and push in the same cycle when empty is not a bypass. A write reaches the SRAM no earlier than one cycle after acceptance.
- Arbiter, evaluated every cycle:
  - W = FIFO non-empty; R = rd_req.
  - Grant the read if R && !(W && (starve_cnt >= STARVE_LIMIT || fifo_full)). Otherwise grant the write if W.
  - starve_cnt increments each cycle W is true and a read wins. It resets to 0 on any write grant or when W is false.
- SRAM drive is registered, one cycle after grant:
  - Write: mem_en=1, mem_we=1, head addr/data, FIFO pops, wr_cnt++.
  - Read: rd_gnt=1 in the grant cycle; mem_en=1, mem_we=0, mem_addr=rd_addr next cycle. rd_data=mem_rdata and rd_dvalid=1 one cycle after that. Read latency from rd_gnt to rd_dvalid is 2 cycles.
  - rd_data holds its value when rd_dvalid=0.
- Ordering: writes commit in acceptance order. A read granted after a write's grant observes that write.
- idle = FIFO empty && no write grant in the current or previous cycle.

Test Plan:
- Reset, then push 4 beats at addrs 0..3 with data 0xA0..0xA3, rd_req=0 -> SRAM writes at mem_addr 0..3 in consecutive cycles, first one cycle after acceptance; wr_cnt=4; idle=1 after drain.
- BASE_ADDR=0x100, push addrs 0xFF, 0x100, 0x100+2^MEM_AW -> only 0x100 written, to mem_addr 0; drop_cnt=2, drop_err=1. Then pulse drop_clr -> both cleared.
- Hold rd_req=1 continuously while streaming 20 writes with FIFO_DEPTH=4 -> every write commits. No write waits more than STARVE_LIMIT+1 cycles; i0_ready deasserts when full and reasserts after a pop.
- Write 0xDEADBEEF to addr 5, then read addr 5 in the next cycle -> rd_dvalid 2 cycles after rd_gnt with rd_data=0xDEADBEEF.
- Assert rst_n low with 3 entries buffered -> all outputs reach reset values immediately, no mem_we after release; wr_cnt=0.
- Force 65540 drops -> drop_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/dma_in_mem_bridge_if.sv
// dma_in_mem_bridge_if: dma_in write stream, core read port and SRAM port of the bridge.
interface dma_in_mem_bridge_if #(parameter int MEM_AW = 10);
  logic [31:0]       i0_addr;
  logic [31:0]       i0_data;
  logic              i0_valid;
  logic              i0_ready;
  logic              rd_req;
  logic [MEM_AW-1:0] rd_addr;
  logic              rd_gnt;
  logic [31:0]       rd_data;
  logic              rd_dvalid;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  modport master (
    output i0_addr, i0_data, i0_valid, rd_req, rd_addr, mem_rdata,
    input  i0_ready, rd_gnt, rd_data, rd_dvalid, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  i0_addr, i0_data, i0_valid, rd_req, rd_addr, mem_rdata,
    output i0_ready, rd_gnt, rd_data, rd_dvalid, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dma_in_mem_bridge.sv
// dma_in_mem_bridge: buffers dma_in writes in a FIFO and commits them to a shared
// single-port SRAM, arbitrating against core reads with a starvation bound.
module dma_in_mem_bridge #(
  parameter int          MEM_AW       = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dma_in_mem_bridge_if.slave  bus,
  input  logic                drop_clr_i,
  output logic [15:0]         drop_cnt_o,
  output logic                drop_err_o,
  output logic [31:0]         wr_cnt_o,
  output logic                idle_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [31:0]       data;
  } ent_t;
  ent_t              fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              run_q;
  logic              mem_en_q, mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              dvalid_q;
  logic [31:0]       rd_data_q;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              drop_err_q, drop_err_d;
  logic [31:0]       wr_cnt_q;
  logic [31:0]       off;
  logic              full, w, in_win, acc, push, drop, rgnt, wgnt;
  ent_t              head;
  assign off    = bus.i0_addr - BASE_ADDR;
  assign in_win = off[31:MEM_AW] == '0;
  assign full   = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign w      = cnt_q != '0;
  assign acc    = bus.i0_valid && bus.i0_ready;
  assign push   = acc && in_win;
  assign drop   = acc && !in_win;
  assign head   = fifo_q[rp_q];
  // A pending write beats the read once it has starved long enough or the FIFO is full.
  assign rgnt   = run_q && bus.rd_req && !(w && (starve_q >= SW'(STARVE_LIMIT) || full));
  assign wgnt   = w && !rgnt;
  assign bus.i0_ready  = run_q && !full;
  assign bus.rd_gnt    = rgnt;
  assign bus.rd_dvalid = dvalid_q;
  assign bus.rd_data   = dvalid_q ? bus.mem_rdata : rd_data_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign drop_cnt_o = drop_cnt_q;
  assign drop_err_o = drop_err_q;
  assign wr_cnt_o   = wr_cnt_q;
  assign idle_o     = !w && !mem_we_q;
  always_comb begin
    cnt_d      = cnt_q + (PW+1)'(push) - (PW+1)'(wgnt);
    starve_d   = (!w || wgnt) ? '0 : (rgnt && starve_q < SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
    drop_cnt_d = drop_clr_i ? 16'(drop) : (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    drop_err_d = drop_clr_i ? drop : drop_err_q | drop;
  end
  always_ff @(posedge clk) if (push) fifo_q[wp_q] <= '{addr: off[MEM_AW-1:0], data: bus.i0_data};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dvalid_q    <= 1'b0;
      rd_data_q   <= '0;
      drop_cnt_q  <= '0;
      drop_err_q  <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      run_q       <= 1'b1;
      wp_q        <= push ? wp_q + 1'b1 : wp_q;
      rp_q        <= wgnt ? rp_q + 1'b1 : rp_q;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= rgnt || wgnt;
      mem_we_q    <= wgnt;
      mem_addr_q  <= wgnt ? head.addr : rgnt ? bus.rd_addr : mem_addr_q;
      mem_wdata_q <= wgnt ? head.data : mem_wdata_q;
      dvalid_q    <= mem_en_q && !mem_we_q;
      rd_data_q   <= dvalid_q ? bus.mem_rdata : rd_data_q;
      drop_cnt_q  <= drop_cnt_d;
      drop_err_q  <= drop_err_d;
      wr_cnt_q    <= wr_cnt_q + 32'(wgnt);
    end
  end
endmodule

// File: tb/tb_dma_in_mem_bridge.sv
// tb_dma_in_mem_bridge: scoreboard bench for the dma_in to SRAM bridge.
module tb_dma_in_mem_bridge;
  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h100;
  localparam int          LIM  = 8;
  logic        clk = 0, rst_n = 0, drop_clr = 0;
  logic [15:0] drop_cnt;
  logic        drop_err, idle;
  logic [31:0] wr_cnt;
  dma_in_mem_bridge_if #(.MEM_AW(AW)) bus ();
  dma_in_mem_bridge #(.MEM_AW(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(4), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .drop_clr_i(drop_clr),
    .drop_cnt_o(drop_cnt), .drop_err_o(drop_err), .wr_cnt_o(wr_cnt), .idle_o(idle)
  );
  always #5 clk = ~clk;
  logic [31:0] sram [1024];
  always @(posedge clk) if (bus.mem_en) begin
    if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
    else bus.mem_rdata <= sram[bus.mem_addr];
  end
  int n_vec = 0, n_err = 0, cyc = 0, gap = 0, last_we = 0, exp_wr = 0;
  logic [15:0] exp_drop = 0;
  logic        exp_err = 0, saw_nr = 0;
  logic [31:0] rd_exp_val = 0;
  logic [41:0] wq [$];
  logic [31:0] rq [$];
  int          gq [$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc++;
  logic [41:0] e;
  always @(negedge clk) if (rst_n) begin
    if (bus.mem_en && bus.mem_we) begin
      if (wq.size() == 0) check("wr_unexp", 1, 0);
      else begin
        e = wq.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(e[41:32]));
        check("wr_data", bus.mem_wdata, e[31:0]);
      end
      check("starve_gap", 64'(gap <= LIM + 1), 1);
      gap = 0;
      last_we = cyc;
    end else if (wq.size() != 0) gap++;
    else gap = 0;
    if (bus.rd_gnt) begin
      gq.push_back(cyc);
      rq.push_back(rd_exp_val);
    end
    if (bus.rd_dvalid) begin
      if (rq.size() == 0) check("rd_unexp", 1, 0);
      else begin
        check("rd_data", bus.rd_data, rq.pop_front());
        check("rd_lat", 64'(cyc - gq.pop_front()), 2);
      end
    end
  end
  task automatic send(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    bit ok;
    off = a - BASE;
    ok = 0;
    bus.i0_addr = a;
    bus.i0_data = d;
    bus.i0_valid = 1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = bus.i0_ready;
      if (!ok) saw_nr = 1;
      @(posedge clk);
      if (ok) begin
        if (off < 1024) begin
          wq.push_back({off[9:0], d});
          exp_wr++;
        end else begin
          exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 16'd1;
          exp_err = 1;
        end
      end
      #1;
    end
    bus.i0_valid = 0;
    if (!ok) check("i0_timeout", 0, 1);
  endtask
  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = idle && wq.size() == 0;
    end
    if (!ok) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int c0;
    bit ok;
    for (int i = 0; i < 1024; i++) sram[i] = 0;
    bus.i0_addr = 0; bus.i0_data = 0; bus.i0_valid = 0;
    bus.rd_req = 1; bus.rd_addr = 0;
    #12;
    check("rst_i0_ready", 64'(bus.i0_ready), 0);
    check("rst_rd_gnt", 64'(bus.rd_gnt), 0);
    check("rst_rd_dvalid", 64'(bus.rd_dvalid), 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_mem_en", 64'(bus.mem_en), 0);
    check("rst_mem_we", 64'(bus.mem_we), 0);
    check("rst_mem_addr", 64'(bus.mem_addr), 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_drop_cnt", 64'(drop_cnt), 0);
    check("rst_drop_err", 64'(drop_err), 0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_idle", 64'(idle), 1);
    bus.rd_req = 0;
    tick(1);
    rst_n = 1;
    tick(1);
    check("ready_after_rst", 64'(bus.i0_ready), 1);
    // back-to-back writes, no reads
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(BASE + i, 32'hA0 + i);
    drain();
    check("t1_last_commit", 64'(last_we - c0), 5);
    check("t1_wr_cnt", wr_cnt, 32'(exp_wr));
    check("t1_idle", 64'(idle), 1);
    // window check and drop counter
    send(32'hFF, 32'h1);
    send(BASE, 32'h55);
    send(BASE + 1024, 32'h2);
    drain();
    check("t2_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check("t2_drop_err", 64'(drop_err), 64'(exp_err));
    check("t2_wr_cnt", wr_cnt, 32'(exp_wr));
    drop_clr = 1; tick(1); drop_clr = 0;
    exp_drop = 0; exp_err = 0;
    tick(1);
    check("t2_clr_cnt", 64'(drop_cnt), 64'(exp_drop));
    check("t2_clr_err", 64'(drop_err), 64'(exp_err));
    drop_clr = 1; exp_drop = 0; exp_err = 0;
    send(32'h0, 32'h3);
    drop_clr = 0;
    check("t2_clr_drop_cnt", 64'(drop_cnt), 1);
    check("t2_clr_drop_err", 64'(drop_err), 1);
    drop_clr = 1; tick(1); drop_clr = 0;
    exp_drop = 0; exp_err = 0;
    // write then read back
    send(BASE + 5, 32'hDEADBEEF);
    tick(1);
    rd_exp_val = 32'hDEADBEEF; bus.rd_addr = 5; bus.rd_req = 1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.rd_gnt;
      @(posedge clk);
      #1;
    end
    bus.rd_req = 0;
    if (!ok) check("rd_gnt_timeout", 0, 1);
    tick(4);
    check("t4_rd_done", 64'(rq.size()), 0);
    check("t4_rd_hold", bus.rd_data, 32'hDEADBEEF);
    // writes under a continuously held read request
    rd_exp_val = 0; bus.rd_addr = 10'd1023; bus.rd_req = 1;
    send(BASE + 10, 32'h1234);
    drain();
    saw_nr = 0;
    for (int i = 0; i < 20; i++) send(BASE + 32 + i, 32'(i * 3 + 7));
    drain();
    check("t3_saw_full", 64'(saw_nr), 1);
    bus.rd_req = 0;
    tick(4);
    check("t3_wr_cnt", wr_cnt, 32'(exp_wr));
    check("t3_rd_done", 64'(rq.size()), 0);
    // reset with writes buffered
    bus.rd_req = 1;
    for (int i = 0; i < 3; i++) send(BASE + 100 + i, 32'hC0 + i);
    rst_n = 0;
    bus.rd_req = 0;
    #1;
    check("t5_mem_en", 64'(bus.mem_en), 0);
    check("t5_mem_we", 64'(bus.mem_we), 0);
    check("t5_i0_ready", 64'(bus.i0_ready), 0);
    check("t5_rd_dvalid", 64'(bus.rd_dvalid), 0);
    check("t5_wr_cnt", wr_cnt, 0);
    check("t5_idle", 64'(idle), 1);
    wq.delete(); rq.delete(); gq.delete();
    gap = 0; exp_wr = 0; exp_drop = 0; exp_err = 0;
    tick(2);
    rst_n = 1;
    tick(15);
    check("t5_post_wr_cnt", wr_cnt, 32'(exp_wr));
    check("t5_post_idle", 64'(idle), 1);
    // drop counter saturation
    for (int i = 0; i < 65540; i++) send(32'h0, 32'(i));
    tick(1);
    check("t6_drop_sat", 64'(drop_cnt), 64'(exp_drop));
    check("t6_drop_sat_abs", 64'(drop_cnt), 64'hFFFF);
    check("t6_drop_err", 64'(drop_err), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
